// File: rtl/core_pkg.sv
// Shared core definitions: register address width, opcode constants and the
// hazard controller's FSM state and hazard-select encodings.
package core_pkg;

   localparam int unsigned REG_AW = 5;

   localparam logic [6:0] OP_R = 7'h33;
   localparam logic [6:0] OP_B = 7'h63;

   typedef logic [1:0] hz_state_t;
   localparam hz_state_t StRun     = 2'd0;
   localparam hz_state_t StMemWait = 2'd1;
   localparam hz_state_t StErr     = 2'd2;

   // Winning hazard after priority resolution (memstall > redirect > loaduse).
   typedef logic [1:0] hz_sel_t;
   localparam hz_sel_t HzNone  = 2'd0;
   localparam hz_sel_t HzMem   = 2'd1;
   localparam hz_sel_t HzRedir = 2'd2;
   localparam hz_sel_t HzLoad  = 2'd3;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector and hazard priority encoder.
module hazard_detect #(
   parameter int unsigned REG_AW = core_pkg::REG_AW
) (
   input  logic              [REG_AW-1:0] id_rs1_i,
   input  logic              [REG_AW-1:0] id_rs2_i,
   input  logic                           use_rs1_i,
   input  logic                           use_rs2_i,
   input  logic              [REG_AW-1:0] ex_rd_i,
   input  logic                           ex_mem_read_i,
   input  logic                           ex_redirect_i,
   input  logic                           mem_req_i,
   input  logic                           mem_ready_i,
   output core_pkg::hz_sel_t              sel_o
);
   import core_pkg::*;

   logic loaduse;
   logic memstall;

   always_comb begin
      loaduse  = ex_mem_read_i && (ex_rd_i != '0) &&
                 ((use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                  (use_rs2_i && (ex_rd_i == id_rs2_i)));
      memstall = mem_req_i && !mem_ready_i;

      if (memstall) begin
         sel_o = HzMem;
      end else if (ex_redirect_i) begin
         sel_o = HzRedir;
      end else if (loaduse) begin
         sel_o = HzLoad;
      end else begin
         sel_o = HzNone;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: Mealy FSM for memory waits with timeout,
// plus saturating stall-cycle and flush performance counters.
module hazard_stall_ctrl #(
   parameter int unsigned REG_AW      = core_pkg::REG_AW,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] IF_ID_rs1,
   input  logic [REG_AW-1:0] IF_ID_rs2,
   input  logic              use_rs1,
   input  logic              use_rs2,
   input  logic [REG_AW-1:0] ID_EX_rd,
   input  logic              ID_EX_MemRead,
   input  logic              EX_redirect,
   input  logic              EX_MEM_MemReq,
   input  logic              MemReady,
   output logic              PCWrite,
   output logic              IF_IDWrite,
   output logic              IF_IDFlush,
   output logic              ID_EXBubble,
   output logic              PipeFreeze,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);
   import core_pkg::*;

   localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

   hz_state_t        state_q, state_d;
   hz_sel_t          sel;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             redirect_flush;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_detect (
      .id_rs1_i      (IF_ID_rs1),
      .id_rs2_i      (IF_ID_rs2),
      .use_rs1_i     (use_rs1),
      .use_rs2_i     (use_rs2),
      .ex_rd_i       (ID_EX_rd),
      .ex_mem_read_i (ID_EX_MemRead),
      .ex_redirect_i (EX_redirect),
      .mem_req_i     (EX_MEM_MemReq),
      .mem_ready_i   (MemReady),
      .sel_o         (sel)
   );

   always_comb begin
      PCWrite        = 1'b1;
      IF_IDWrite     = 1'b1;
      IF_IDFlush     = 1'b0;
      ID_EXBubble    = 1'b0;
      PipeFreeze     = 1'b0;
      redirect_flush = 1'b0;
      state_d        = state_q;
      wait_cnt_d     = '0;
      mem_timeout_d  = mem_timeout_q;

      if (state_q == StErr) begin
         PCWrite     = 1'b0;
         IF_IDWrite  = 1'b0;
         PipeFreeze  = 1'b1;
         ID_EXBubble = 1'b1;
      end else begin
         unique case (sel)
            HzMem: begin
               PCWrite    = 1'b0;
               IF_IDWrite = 1'b0;
               PipeFreeze = 1'b1;
               state_d    = StMemWait;
               if (state_q == StMemWait) begin
                  if (wait_cnt_q == WaitLast) begin
                     state_d       = StErr;
                     mem_timeout_d = 1'b1;
                  end else begin
                     wait_cnt_d = wait_cnt_q + WaitW'(1);
                  end
               end
            end
            HzRedir: begin
               IF_IDFlush     = 1'b1;
               ID_EXBubble    = 1'b1;
               redirect_flush = 1'b1;
               state_d        = StRun;
            end
            HzLoad: begin
               PCWrite     = 1'b0;
               IF_IDWrite  = 1'b0;
               ID_EXBubble = 1'b1;
               state_d     = StRun;
            end
            HzNone: begin
               state_d = StRun;
            end
         endcase
      end

      stall_d = (!PCWrite && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
      flush_d = (redirect_flush && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;

      // Reset forces a safe bubble/flush pattern regardless of pipeline state.
      if (rst) begin
         PCWrite     = 1'b0;
         IF_IDWrite  = 1'b0;
         IF_IDFlush  = 1'b1;
         ID_EXBubble = 1'b1;
         PipeFreeze  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_q       <= '0;
         flush_q       <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_q       <= stall_d;
         flush_q       <= flush_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
   logic       use_rs1, use_rs2, ID_EX_MemRead, EX_redirect, EX_MEM_MemReq, MemReady;
   logic       PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, PipeFreeze, mem_timeout;
   logic [3:0] stall_cycles, flush_count;

   int n_checks = 0;
   int n_errors = 0;

   hazard_stall_ctrl #(
      .REG_AW      (5),
      .CNT_W       (4),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .IF_ID_rs1     (IF_ID_rs1),
      .IF_ID_rs2     (IF_ID_rs2),
      .use_rs1       (use_rs1),
      .use_rs2       (use_rs2),
      .ID_EX_rd      (ID_EX_rd),
      .ID_EX_MemRead (ID_EX_MemRead),
      .EX_redirect   (EX_redirect),
      .EX_MEM_MemReq (EX_MEM_MemReq),
      .MemReady      (MemReady),
      .PCWrite       (PCWrite),
      .IF_IDWrite    (IF_IDWrite),
      .IF_IDFlush    (IF_IDFlush),
      .ID_EXBubble   (ID_EXBubble),
      .PipeFreeze    (PipeFreeze),
      .mem_timeout   (mem_timeout),
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Control vector order: {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, PipeFreeze}.
   task automatic chk_ctl(input string tag, input logic [4:0] exp);
      #1;
      chk(tag, {27'd0, PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, PipeFreeze}, {27'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      IF_ID_rs1     = '0;
      IF_ID_rs2     = '0;
      ID_EX_rd      = '0;
      use_rs1       = 1'b0;
      use_rs2       = 1'b0;
      ID_EX_MemRead = 1'b0;
      EX_redirect   = 1'b0;
      EX_MEM_MemReq = 1'b0;
      MemReady      = 1'b0;
   endtask

   task automatic set_loaduse();
      ID_EX_MemRead = 1'b1;
      ID_EX_rd      = 5'd5;
      IF_ID_rs1     = 5'd5;
      use_rs1       = 1'b1;
   endtask

   initial begin
      clear();
      rst = 1'b1;
      chk_ctl("reset_outputs", 5'b00110);
      tick();
      tick();
      chk("reset_stall", stall_cycles, 0);
      chk("reset_flush", flush_count, 0);
      chk("reset_timeout", mem_timeout, 0);

      rst = 1'b0;
      chk_ctl("idle", 5'b11000);
      tick();
      chk("idle_stall", stall_cycles, 0);

      // Load-use stalls exactly one cycle.
      set_loaduse();
      chk_ctl("loaduse", 5'b00010);
      tick();
      ID_EX_MemRead = 1'b0;
      chk_ctl("loaduse_release", 5'b11000);
      chk("loaduse_stall", stall_cycles, 1);

      // x0 destination and unused rs2 never stall.
      ID_EX_MemRead = 1'b1;
      ID_EX_rd      = 5'd0;
      IF_ID_rs1     = 5'd0;
      chk_ctl("rd_x0", 5'b11000);
      use_rs1   = 1'b0;
      ID_EX_rd  = 5'd7;
      IF_ID_rs2 = 5'd7;
      chk_ctl("rs2_unused", 5'b11000);
      use_rs2 = 1'b1;
      chk_ctl("rs2_used", 5'b00010);

      // Redirect beats load-use.
      clear();
      set_loaduse();
      EX_redirect = 1'b1;
      chk_ctl("redirect_loaduse", 5'b11110);
      tick();
      clear();
      chk("redirect_flush_cnt", flush_count, 1);
      chk("redirect_stall_cnt", stall_cycles, 1);

      // Three frozen cycles with a held redirect, then one flush on MemReady.
      EX_MEM_MemReq = 1'b1;
      EX_redirect   = 1'b1;
      chk_ctl("memwait_run", 5'b00001);
      tick();
      chk_ctl("memwait_1", 5'b00001);
      tick();
      chk_ctl("memwait_2", 5'b00001);
      tick();
      MemReady = 1'b1;
      chk_ctl("memready_redirect", 5'b11110);
      tick();
      chk("memwait_flush_cnt", flush_count, 2);
      chk("memwait_stall_cnt", stall_cycles, 4);
      clear();
      chk_ctl("memwait_done", 5'b11000);
      tick();
      chk("memwait_flush_once", flush_count, 2);

      // Timeout: RUN cycle plus four MEM_WAIT cycles, then ERR.
      EX_MEM_MemReq = 1'b1;
      chk_ctl("to_run", 5'b00001);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_ctl("to_wait", 5'b00001);
         chk("to_not_yet", mem_timeout, 0);
         tick();
      end
      chk_ctl("err_outputs", 5'b00011);
      chk("err_timeout", mem_timeout, 1);
      clear();
      EX_redirect = 1'b1;
      chk_ctl("err_sticky_ctl", 5'b00011);
      tick();
      chk("err_sticky_to", mem_timeout, 1);
      chk("err_stall_cnt", stall_cycles, 10);
      chk("err_flush_cnt", flush_count, 2);

      // Reset leaves ERR and clears everything.
      rst = 1'b1;
      chk_ctl("rst_in_err", 5'b00110);
      tick();
      rst = 1'b0;
      clear();
      chk_ctl("after_rst", 5'b11000);
      chk("after_rst_stall", stall_cycles, 0);
      chk("after_rst_flush", flush_count, 0);
      chk("after_rst_to", mem_timeout, 0);

      // Reset mid-wait abandons the wait and restarts the timeout window.
      EX_MEM_MemReq = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b1;
      chk_ctl("rst_midwait", 5'b00110);
      tick();
      rst = 1'b0;
      chk("midwait_stall_clr", stall_cycles, 0);
      for (int i = 0; i < 4; i++) tick();
      chk_ctl("midwait_no_err", 5'b00001);
      chk("midwait_no_to", mem_timeout, 0);
      chk("midwait_stall", stall_cycles, 4);
      MemReady = 1'b1;
      chk_ctl("midwait_ready", 5'b11000);
      tick();
      clear();

      // Saturation of the 4-bit stall counter.
      set_loaduse();
      for (int i = 0; i < 11; i++) tick();
      chk("sat_reach", stall_cycles, 15);
      for (int i = 0; i < 9; i++) tick();
      chk("sat_hold", stall_cycles, 15);
      clear();
      chk_ctl("final_idle", 5'b11000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
